// File: rtl/ssfpm_norm_round_pack.sv
// Normalize / round-to-nearest-even / pack stage of the segmented approximate
// FP32 multiplier. Two-stage valid/ready pipeline producing IEEE-754 singles.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid / in_ready         upstream handshake
//   in_sign                     product sign
//   in_exp_a, in_exp_b          raw biased operand exponents
//   in_frac_nz_a, in_frac_nz_b  operand fraction fields nonzero
//   in_mant                     significand product, value in_mant/2**(FRAC_W+1)
//   out_valid / out_ready       downstream handshake
//   out_result                  packed single-precision result
//   out_ovf, out_unf, out_inv   overflow, underflow flush, invalid flags
module ssfpm_norm_round_pack #(
    parameter int                    EXP_W  = 8,
    parameter int                    FRAC_W = 23,
    parameter logic [EXP_W+FRAC_W:0] QNAN   = 32'h7FC00000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp_a,
    input  logic [EXP_W-1:0]        in_exp_b,
    input  logic                    in_frac_nz_a,
    input  logic                    in_frac_nz_b,
    input  logic [FRAC_W+2:0]       in_mant,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_result,
    output logic                    out_ovf,
    output logic                    out_unf,
    output logic                    out_inv
);

    localparam int MANT_W = FRAC_W + 3;
    localparam int EW     = EXP_W + 2;

    localparam logic [EW-1:0]        BIAS = EW'(2 ** (EXP_W - 1) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'(2 ** EXP_W - 1);
    localparam logic [EW-1:0]        ONE  = EW'(1);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic s2_adv;
    logic accept;

    assign s2_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_adv;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;

    // ------------------------------------------------------------------
    // Stage 1: classify, add exponents, normalize by at most one bit
    // ------------------------------------------------------------------
    logic a_zero, b_zero;
    logic a_ones, b_ones;
    logic any_nan, any_inf, any_zero;

    assign a_zero = (in_exp_a == '0);
    assign b_zero = (in_exp_b == '0);
    assign a_ones = &in_exp_a;
    assign b_ones = &in_exp_b;

    assign any_nan  = (a_ones && in_frac_nz_a) || (b_ones && in_frac_nz_b);
    assign any_inf  = (a_ones && !in_frac_nz_a) || (b_ones && !in_frac_nz_b);
    assign any_zero = a_zero || b_zero;

    logic [EW-1:0]     e_sum;
    logic [EW-1:0]     n_e;
    logic [FRAC_W-1:0] n_frac;
    logic              n_guard;
    logic              n_sticky;

    // Two guard-side bits are available when the product is in [2,4);
    // in [1,2) only one bit falls below the fraction, so sticky is empty.
    assign e_sum = {2'b00, in_exp_a} + {2'b00, in_exp_b} - BIAS;

    always_comb begin
        n_e      = e_sum;
        n_frac   = in_mant[MANT_W-3:1];
        n_guard  = in_mant[0];
        n_sticky = 1'b0;
        if (in_mant[MANT_W-1]) begin
            n_e      = e_sum + ONE;
            n_frac   = in_mant[MANT_W-2:2];
            n_guard  = in_mant[1];
            n_sticky = in_mant[0];
        end
    end

    logic                    s1_sign;
    logic signed [EW-1:0]    s1_e;
    logic [FRAC_W-1:0]       s1_frac;
    logic                    s1_guard;
    logic                    s1_sticky;
    logic                    s1_nan;
    logic                    s1_inf;
    logic                    s1_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_e      <= '0;
            s1_frac   <= '0;
            s1_guard  <= 1'b0;
            s1_sticky <= 1'b0;
            s1_nan    <= 1'b0;
            s1_inf    <= 1'b0;
            s1_zero   <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (accept) begin
                s1_sign   <= in_sign;
                s1_e      <= n_e;
                s1_frac   <= n_frac;
                s1_guard  <= n_guard;
                s1_sticky <= n_sticky;
                s1_nan    <= any_nan;
                s1_inf    <= any_inf;
                s1_zero   <= any_zero;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round to nearest even, resolve specials, pack
    // ------------------------------------------------------------------
    logic [FRAC_W:0]      frac_inc;
    logic                 round_up;
    logic [FRAC_W-1:0]    r_frac;
    logic signed [EW-1:0] r_e;
    logic                 r_big;
    logic                 r_small;

    assign frac_inc = {1'b0, s1_frac} + (FRAC_W + 1)'(1);
    assign round_up = s1_guard && (s1_sticky || s1_frac[0]);

    // A carry out of the fraction leaves the significand at exactly 2.0,
    // which renormalizes to a zero fraction one binade up.
    always_comb begin
        r_frac = s1_frac;
        r_e    = s1_e;
        if (round_up) begin
            if (frac_inc[FRAC_W]) begin
                r_frac = '0;
                r_e    = s1_e + ONE;
            end else begin
                r_frac = frac_inc[FRAC_W-1:0];
            end
        end
    end

    assign r_big   = !r_e[EW-1] && (r_e >= EMAX);
    assign r_small = r_e[EW-1] || (r_e == '0);

    logic [EXP_W+FRAC_W:0] d_result;
    logic                  d_ovf;
    logic                  d_unf;
    logic                  d_inv;

    always_comb begin
        d_result = '0;
        d_ovf    = 1'b0;
        d_unf    = 1'b0;
        d_inv    = 1'b0;
        if (s1_nan || (s1_inf && s1_zero)) begin
            d_result = QNAN;
            d_inv    = 1'b1;
        end else if (s1_inf) begin
            d_result = {s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (s1_zero) begin
            d_result = {s1_sign, {(EXP_W + FRAC_W){1'b0}}};
        end else if (r_big) begin
            d_result = {s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            d_ovf    = 1'b1;
        end else if (r_small) begin
            d_result = {s1_sign, {(EXP_W + FRAC_W){1'b0}}};
            d_unf    = 1'b1;
        end else begin
            d_result = {s1_sign, r_e[EXP_W-1:0], r_frac};
        end
    end

    // Output registers only move when the downstream side can take them,
    // so a stalled result and its flags stay put.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_ovf    <= 1'b0;
            out_unf    <= 1'b0;
            out_inv    <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= d_result;
                out_ovf    <= d_ovf;
                out_unf    <= d_unf;
                out_inv    <= d_inv;
            end else begin
                out_result <= '0;
                out_ovf    <= 1'b0;
                out_unf    <= 1'b0;
                out_inv    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ssfpm_norm_round_pack.sv
// Self-checking bench for ssfpm_norm_round_pack: directed vectors, random
// stream against an arithmetic reference model, backpressure and reset.
module tb_ssfpm_norm_round_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp_a;
    logic [7:0]  in_exp_b;
    logic        in_frac_nz_a;
    logic        in_frac_nz_b;
    logic [25:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_ovf;
    logic        out_unf;
    logic        out_inv;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        s;
        int          ea;
        int          eb;
        logic        na;
        logic        nb;
        logic [25:0] mant;
    } op_t;

    ssfpm_norm_round_pack dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp_a     (in_exp_a),
        .in_exp_b     (in_exp_b),
        .in_frac_nz_a (in_frac_nz_a),
        .in_frac_nz_b (in_frac_nz_b),
        .in_mant      (in_mant),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_ovf      (out_ovf),
        .out_unf      (out_unf),
        .out_inv      (out_inv)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: value = mant * 2**-24 * 2**(ea+eb-254), rounded to 24
    // significant bits with ties to even. Returns {inv, ovf, unf, result}.
    function automatic logic [34:0] model(input op_t o);
        bit     za, zb, ia, ib, xa, xb;
        int     e, sh;
        longint m, q, rem, half;
        logic [31:0] r;
        za = (o.ea == 0);
        zb = (o.eb == 0);
        ia = (o.ea == 255) && !o.na;
        ib = (o.eb == 255) && !o.nb;
        xa = (o.ea == 255) && o.na;
        xb = (o.eb == 255) && o.nb;
        if (xa || xb || ((ia || ib) && (za || zb)))
            return {3'b100, 32'h7FC00000};
        if (ia || ib)
            return {3'b000, o.s, 8'hFF, 23'h0};
        if (za || zb)
            return {3'b000, o.s, 31'h0};
        m  = longint'(o.mant);
        sh = (m >= 64'd33554432) ? 2 : 1;
        e  = o.ea + o.eb - 127 + (sh - 1);
        q    = m >> sh;
        rem  = m - (q << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && q[0]))
            q = q + 1;
        if (q >= 64'd16777216) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255)
            return {3'b010, o.s, 8'hFF, 23'h0};
        if (e <= 0)
            return {3'b001, o.s, 31'h0};
        r = {o.s, 8'(e), 23'(q - 64'd8388608)};
        return {3'b000, r};
    endfunction

    function automatic op_t mk(input logic s, input int ea, input int eb,
                               input logic na, input logic nb,
                               input logic [25:0] m);
        op_t o;
        o.s = s; o.ea = ea; o.eb = eb;
        o.na = na; o.nb = nb; o.mant = m;
        return o;
    endfunction

    function automatic int rand_exp();
        int k;
        k = int'($urandom_range(0, 11));
        if (k == 0) return 0;
        if (k == 1) return 255;
        if (k < 5)  return int'($urandom_range(1, 254));
        return int'($urandom_range(90, 170));
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.s    = 1'($urandom_range(0, 1));
        o.ea   = rand_exp();
        o.eb   = rand_exp();
        o.na   = 1'($urandom_range(0, 1));
        o.nb   = 1'($urandom_range(0, 1));
        o.mant = 26'($urandom_range(32'h1000000, 32'h3FFFFFF));
        return o;
    endfunction

    task automatic drive(input op_t o);
        in_sign      = o.s;
        in_exp_a     = o.ea[7:0];
        in_exp_b     = o.eb[7:0];
        in_frac_nz_a = o.na;
        in_frac_nz_b = o.nb;
        in_mant      = o.mant;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 26'h0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b, expected 0/1",
                     out_valid, in_ready);
        end
        checks++;
        if ({out_inv, out_ovf, out_unf, out_result} !== 35'h0) begin
            errors++;
            $display("FAIL reset_out: flags=%b result=%h, expected 000/00000000",
                     {out_inv, out_ovf, out_unf}, out_result);
        end
    endtask

    // One op with out_ready high; result must appear exactly 2 cycles on.
    task automatic send_check(input op_t o, input logic [31:0] er,
                              input logic [2:0] ef, input string name);
        @(negedge clk);
        drive(o);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: in_ready=%b, expected 1", name, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_early: out_valid=%b after 1 cycle, expected 0",
                     name, out_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_result !== er ||
            {out_inv, out_ovf, out_unf} !== ef) begin
            errors++;
            $display("FAIL %s: valid=%b result=%h flags=%b, expected valid=1 result=%h flags=%b",
                     name, out_valid, out_result,
                     {out_inv, out_ovf, out_unf}, er, ef);
        end
    endtask

    task automatic test_directed();
        send_check(mk(0, 127, 127, 0, 0, 26'h1000000), 32'h3F800000, 3'b000, "one");
        send_check(mk(0, 127, 127, 0, 0, 26'h2400000), 32'h40100000, 3'b000, "norm_2p25");
        send_check(mk(0, 127, 127, 0, 0, 26'h1FFFFFF), 32'h40000000, 3'b000, "round_carry");
        send_check(mk(0, 127, 127, 0, 0, 26'h1000001), 32'h3F800000, 3'b000, "tie_even");
        send_check(mk(0, 127, 127, 0, 0, 26'h1000003), 32'h3F800002, 3'b000, "tie_odd");
        send_check(mk(0, 127, 127, 0, 0, 26'h2000006), 32'h40000002, 3'b000, "hi_tie_odd");
        send_check(mk(0, 127, 127, 0, 0, 26'h2000003), 32'h40000001, 3'b000, "hi_sticky");
        send_check(mk(0, 254, 254, 0, 0, 26'h1000000), 32'h7F800000, 3'b010, "ovf");
        send_check(mk(1, 1, 1, 0, 0, 26'h1000000), 32'h80000000, 3'b001, "unf");
        send_check(mk(0, 255, 0, 0, 0, 26'h1000000), 32'h7FC00000, 3'b100, "inf_x_zero");
        send_check(mk(1, 255, 128, 0, 0, 26'h1000000), 32'hFF800000, 3'b000, "inf");
        send_check(mk(0, 100, 255, 0, 1, 26'h1000000), 32'h7FC00000, 3'b100, "nan");
        send_check(mk(1, 0, 130, 0, 0, 26'h1800000), 32'h80000000, 3'b000, "zero");
        send_check(mk(0, 127, 254, 0, 0, 26'h1000000), 32'h7F000000, 3'b000, "emax");
        send_check(mk(0, 128, 254, 0, 0, 26'h1000000), 32'h7F800000, 3'b010, "e255");
        send_check(mk(0, 127, 254, 0, 0, 26'h3FFFFFF), 32'h7F800000, 3'b010, "round_ovf");
        send_check(mk(0, 1, 127, 0, 0, 26'h1000000), 32'h00800000, 3'b000, "emin");
        send_check(mk(0, 1, 126, 0, 0, 26'h1000000), 32'h00000000, 3'b001, "e0");
        send_check(mk(0, 1, 126, 0, 0, 26'h1FFFFFF), 32'h00800000, 3'b000, "round_to_emin");
    endtask

    task automatic test_random(input int ncyc);
        logic [34:0] q[$];
        logic [34:0] prev;
        logic [34:0] got;
        logic [34:0] exp_v;
        op_t         cur;
        bit          have;
        bit          stall_prev;
        have       = 0;
        stall_prev = 0;
        prev       = '0;
        cur        = mk(0, 0, 0, 0, 0, 26'h0);
        for (int c = 0; c < ncyc + 40; c++) begin
            @(negedge clk);
            if (!have && c < ncyc && $urandom_range(0, 3) != 0) begin
                cur  = rand_op();
                have = 1;
            end
            in_valid = have;
            drive(cur);
            out_ready = (c >= ncyc) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
            #1;
            got = {out_inv, out_ovf, out_unf, out_result};
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || got !== prev) begin
                    errors++;
                    $display("FAIL rand_hold: valid=%b out=%h, expected valid=1 out=%h",
                             out_valid, got, prev);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(cur));
                have = 0;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: out=%h, expected no output", got);
                end else begin
                    exp_v = q.pop_front();
                    if (got !== exp_v) begin
                        errors++;
                        $display("FAIL rand_data: out=%h, expected %h", got, exp_v);
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            prev       = got;
        end
        in_valid = 1'b0;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rand_drain: %0d results missing, expected 0", q.size());
        end
    endtask

    task automatic test_backpressure();
        op_t         ops[3];
        logic [34:0] ev[3];
        logic [34:0] got;
        int          acc;
        ops[0] = mk(0, 127, 128, 0, 0, 26'h1400000);
        ops[1] = mk(1, 120, 130, 0, 0, 26'h2C00001);
        ops[2] = mk(0, 140, 100, 0, 0, 26'h1abcdef);
        for (int i = 0; i < 3; i++) ev[i] = model(ops[i]);
        acc = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(ops[acc]);
            in_valid = 1'b1;
            #1;
            if (in_ready) acc++;
        end
        checks++;
        if (acc != 2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept: accepted=%0d in_ready=%b, expected 2/0",
                     acc, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            got = {out_inv, out_ovf, out_unf, out_result};
            checks++;
            if (out_valid !== 1'b1 || got !== ev[0] || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: valid=%b out=%h in_ready=%b, expected 1/%h/0",
                         out_valid, got, in_ready, ev[0]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (k == 0);
            #1;
            got = {out_inv, out_ovf, out_unf, out_result};
            checks++;
            if (out_valid !== 1'b1 || got !== ev[k]) begin
                errors++;
                $display("FAIL bp_drain%0d: valid=%b out=%h, expected 1/%h",
                         k, out_valid, got, ev[k]);
            end
            if (k == 0) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_refill: in_ready=%b, expected 1", in_ready);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_dup: out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        @(negedge clk);
        drive(mk(0, 127, 127, 0, 0, 26'h1000000));
        in_valid = 1'b1;
        @(negedge clk);
        drive(mk(1, 130, 127, 0, 0, 26'h2000000));
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: out_valid=%b, expected 0", out_valid);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rst_flush%0d: out_valid=%b in_ready=%b, expected 0/1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(2000);
        test_backpressure();
        test_random(300);
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
